// File: rtl/rr_mux_sel_arbiter4_pkg.sv
// Shared types and helpers for the 4-way round-robin mux-select arbiter.
package rr_mux_sel_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] onehot_to_index(input logic [NUM_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = idx | SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_sel_arbiter4_if.sv
// Request/grant bundle between the requesters and the arbiter feeding mux4to1.
interface rr_mux_sel_arbiter4_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       valid;
    logic       s1;
    logic       s0;

    modport master (output req, done, input gnt, valid, s1, s0);
    modport slave  (input req, done, output gnt, valid, s1, s0);
endinterface

// File: rtl/rr_mux_sel_arbiter4_pick4.sv
// rr_pick4: combinational rotating-priority finder, searching last+1 .. last (mod 4).
module rr_pick4
    import rr_mux_sel_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   winner,
    output logic               found
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_sel_arbiter4.sv
// Round-robin arbiter driving the s1/s0 selects of mux4to1.
// Optional macro RR_HOLD_TIMEOUT_EN force-releases a grant after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no owner; arbitrate any pending request on the next edge
// GRANT | one requester owns the mux until done, withdrawal or timeout
module rr_mux_sel_arbiter4
    import rr_mux_sel_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    rr_mux_sel_arbiter4_if.slave  bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > (2**CNT_W) - 1) begin : g_bad_max_hold
        $error("MAX_HOLD out of range for CNT_W");
    end

    state_t               state;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 valid_q;
    logic [SEL_W-1:0]     sel_q;
    logic [SEL_W-1:0]     last_q;
    logic [SEL_W-1:0]     owner;
    logic [SEL_W-1:0]     winner;
    logic                 found;
    logic                 timeout;
    logic                 release_now;

    assign owner = onehot_to_index(gnt_q);

    rr_pick4 u_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (winner),
        .found  (found)
    );

`ifdef RR_HOLD_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    assign timeout = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign timeout = 1'b0;
`endif

    assign release_now = bus.done || !bus.req[owner] || timeout;

    // s1/s0 deliberately keep the last owner across IDLE so the mux output stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_REQ - 1);
`ifdef RR_HOLD_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef RR_HOLD_TIMEOUT_EN
                    hold_cnt <= '0;
`endif
                    if (found) begin
                        state   <= GRANT;
                        gnt_q   <= NUM_REQ'(1) << winner;
                        valid_q <= 1'b1;
                        sel_q   <= winner;
                    end
                end
                GRANT: begin
`ifdef RR_HOLD_TIMEOUT_EN
                    hold_cnt <= hold_cnt + 1'b1;
`endif
                    if (release_now) begin
                        state   <= IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        last_q  <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];

endmodule

// File: tb/tb_rr_mux_sel_arbiter4.sv
// Directed bench for rr_mux_sel_arbiter4 with a cycle-level reference model.
module tb_rr_mux_sel_arbiter4;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    rr_mux_sel_arbiter4_if bus ();

    rr_mux_sel_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), last owner, held select, cycles held.
    int m_owner = -1;
    int m_last  = 3;
    int m_sel   = 0;
    int m_hold  = 0;

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic bit timed_out(input int held);
`ifdef RR_HOLD_TIMEOUT_EN
        return held >= MAX_HOLD;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_last  <= 3;
            m_sel   <= 0;
            m_hold  <= 0;
        end else if (m_owner < 0) begin
            if (pick(bus.req, m_last) >= 0) begin
                m_owner <= pick(bus.req, m_last);
                m_sel   <= pick(bus.req, m_last);
                m_hold  <= 1;
            end
        end else if (bus.done || !bus.req[m_owner] || timed_out(m_hold)) begin
            m_last  <= m_owner;
            m_owner <= -1;
        end else begin
            m_hold <= m_hold + 1;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_gnt", bus.gnt, (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner));
        chk("model_valid", {3'b0, bus.valid}, {3'b0, m_owner >= 0});
        chk("model_sel", {2'b0, bus.s1, bus.s0}, 4'(m_sel));
        chk("onehot0", {3'b0, $onehot0(bus.gnt)}, 4'b0001);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic v, input logic [1:0] s);
        chk({name, "_gnt"}, bus.gnt, g);
        chk({name, "_valid"}, {3'b0, bus.valid}, {3'b0, v});
        chk({name, "_sel"}, {2'b0, bus.s1, bus.s0}, {2'b0, s});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.done = 1'b0;
        #1;
        expect_out("reset", 4'b0000, 1'b0, 2'b00);
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [3:0] exp_seq [5];

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // 1: single request, done release, select held
        do_reset();
        bus.req = 4'b0001;
        step();
        expect_out("t1_grant", 4'b0001, 1'b1, 2'b00);
        bus.done = 1'b1;
        step();
        expect_out("t1_release", 4'b0000, 1'b0, 2'b00);
        bus.done = 1'b0;
        bus.req = 4'b0000;
        step();

        // 2: all requesting, rotation with one bubble each
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            expect_out("t2_grant", exp_seq[k], 1'b1, 2'(k % 4));
            bus.done = 1'b1;
            step();
            expect_out("t2_bubble", 4'b0000, 1'b0, 2'(k % 4));
            bus.done = 1'b0;
        end
        bus.req = 4'b0000;
        step();

        // 3: owner 2 withdraws, index 3 wins over 0 (last=0 before)
        bus.req = 4'b0100;
        step();
        expect_out("t3_grant2", 4'b0100, 1'b1, 2'b10);
        bus.req = 4'b1011;
        step();
        expect_out("t3_withdraw", 4'b0000, 1'b0, 2'b10);
        step();
        expect_out("t3_grant3", 4'b1000, 1'b1, 2'b11);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        bus.req = 4'b0000;
        step();

        // 4: async reset in the middle of a grant
        bus.req = 4'b0010;
        step();
        expect_out("t4_grant1", 4'b0010, 1'b1, 2'b01);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("t4_async_rst", 4'b0000, 1'b0, 2'b00);
        step();
        rst_n = 1'b1;
        bus.req = 4'b1111;
        step();
        expect_out("t4_after_rst", 4'b0001, 1'b1, 2'b00);

        // 6: done and new request together while owner 0 releases
        bus.done = 1'b1;
        bus.req = 4'b0010;
        step();
        expect_out("t6_release", 4'b0000, 1'b0, 2'b00);
        bus.done = 1'b0;
        step();
        expect_out("t6_grant1", 4'b0010, 1'b1, 2'b01);
        bus.done = 1'b1;
        step();
        bus.req = 4'b0000;
        step();
        expect_out("t6_idle_done", 4'b0000, 1'b0, 2'b01);
        bus.done = 1'b0;
        step();
        expect_out("t6_idle_after", 4'b0000, 1'b0, 2'b01);

        // 5: single requester held with no done (last=1, so 2 wins)
        bus.req = 4'b0100;
        step();
        expect_out("t5_grant", 4'b0100, 1'b1, 2'b10);
`ifdef RR_HOLD_TIMEOUT_EN
        for (int k = 1; k < MAX_HOLD; k++) begin
            step();
            expect_out("t5_hold", 4'b0100, 1'b1, 2'b10);
        end
        step();
        expect_out("t5_timeout", 4'b0000, 1'b0, 2'b10);
        step();
        expect_out("t5_regrant", 4'b0100, 1'b1, 2'b10);
`else
        for (int k = 0; k < 55; k++) begin
            step();
            expect_out("t5_hold", 4'b0100, 1'b1, 2'b10);
        end
`endif
        bus.req = 4'b0000;
        step();
        expect_out("t5_withdraw", 4'b0000, 1'b0, 2'b10);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
